// File: rtl/axi_rdata_router.sv
// ---------------------------------------------------------------------------
// axi_rdata_router
// Read-data channel router for a 2-master / 3-slave AXI interconnect. The
// read-address stage pushes one routing entry (issuing master, decoded slave)
// per accepted AR handshake. Entries are served in order: each slave R burst
// is passed combinationally to its issuing master until the RLAST beat, with
// one idle cycle between consecutive bursts. Slave 2 is the default slave.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   ar_push           routing entry strobe from the address stage
//   ar_master         issuing master index (0/1)
//   ar_slave          decoded slave index (3 aliases to 2)
//   ar_full           routing FIFO full
//   outstanding       queued entries plus the active burst
//   s_r*              packed slave R channels (slave k at slice k)
//   m_r*              packed master R channels (master j at slice j)
// ---------------------------------------------------------------------------
module axi_rdata_router #(
   parameter int unsigned ID_W   = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ar_push,
   input  logic                    ar_master,
   input  logic [1:0]              ar_slave,
   output logic                    ar_full,
   output logic [$clog2(DEPTH):0]  outstanding,
   input  logic [3*ID_W-1:0]       s_rid,
   input  logic [3*DATA_W-1:0]     s_rdata,
   input  logic [5:0]              s_rresp,
   input  logic [2:0]              s_rlast,
   input  logic [2:0]              s_rvalid,
   output logic [2:0]              s_rready,
   output logic [2*ID_W-1:0]       m_rid,
   output logic [2*DATA_W-1:0]     m_rdata,
   output logic [3:0]              m_rresp,
   output logic [1:0]              m_rlast,
   output logic [1:0]              m_rvalid,
   input  logic [1:0]              m_rready
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned NUM_S = 3;
   localparam int unsigned NUM_M = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   // Routing FIFO and active route
   state_t            r_state;
   logic              r_fifo_m [DEPTH];
   logic [1:0]        r_fifo_s [DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_sel_m;
   logic [1:0]        r_sel_s;

   logic              w_push;
   logic              w_pop;
   logic              w_last_beat;
   logic [1:0]        w_slave_norm;

   // Per-slave unpacked views of the packed slave buses
   logic [ID_W-1:0]   w_s_rid   [NUM_S];
   logic [DATA_W-1:0] w_s_rdata [NUM_S];
   logic [1:0]        w_s_rresp [NUM_S];

   // Selected-slave signals
   logic              w_sel_rvalid;
   logic              w_sel_rlast;
   logic [ID_W-1:0]   w_sel_rid;
   logic [DATA_W-1:0] w_sel_rdata;
   logic [1:0]        w_sel_rresp;

   // Per-master unpacked views before packing onto the output buses
   logic [ID_W-1:0]   w_m_rid   [NUM_M];
   logic [DATA_W-1:0] w_m_rdata [NUM_M];
   logic [1:0]        w_m_rresp [NUM_M];

   for (genvar k = 0; k < NUM_S; k++) begin : g_unpack_s
      assign w_s_rid[k]   = s_rid[k*ID_W +: ID_W];
      assign w_s_rdata[k] = s_rdata[k*DATA_W +: DATA_W];
      assign w_s_rresp[k] = s_rresp[k*2 +: 2];
   end

   for (genvar j = 0; j < NUM_M; j++) begin : g_pack_m
      assign m_rid[j*ID_W +: ID_W]     = w_m_rid[j];
      assign m_rdata[j*DATA_W +: DATA_W] = w_m_rdata[j];
      assign m_rresp[j*2 +: 2]         = w_m_rresp[j];
   end

   // Slave index 3 does not exist; it aliases onto the default slave
   assign w_slave_norm = (ar_slave == 2'd3) ? 2'd2 : ar_slave;

   assign ar_full     = (r_count == CNT_W'(DEPTH));
   assign outstanding = r_count + CNT_W'(r_state == ST_BURST);

   assign w_push = ar_push & ~ar_full;
   assign w_pop  = (r_state == ST_IDLE) && (r_count != '0);

   assign w_sel_rvalid = s_rvalid[r_sel_s];
   assign w_sel_rlast  = s_rlast[r_sel_s];
   assign w_sel_rid    = w_s_rid[r_sel_s];
   assign w_sel_rdata  = w_s_rdata[r_sel_s];
   assign w_sel_rresp  = w_s_rresp[r_sel_s];

   assign w_last_beat = (r_state == ST_BURST) && w_sel_rvalid &&
                        m_rready[r_sel_m] && w_sel_rlast;

   // Pass-through path from the selected slave to the selected master;
   // data stays zero on any master whose RVALID is low
   always_comb begin
      m_rvalid  = '0;
      m_rlast   = '0;
      s_rready  = '0;
      w_m_rid   = '{default: '0};
      w_m_rdata = '{default: '0};
      w_m_rresp = '{default: '0};
      if (r_state == ST_BURST) begin
         m_rvalid[r_sel_m] = w_sel_rvalid;
         s_rready[r_sel_s] = m_rready[r_sel_m];
         if (w_sel_rvalid) begin
            m_rlast[r_sel_m]   = w_sel_rlast;
            w_m_rid[r_sel_m]   = w_sel_rid;
            w_m_rdata[r_sel_m] = w_sel_rdata;
            w_m_rresp[r_sel_m] = w_sel_rresp;
         end
      end
   end

   // FIFO storage; contents need no reset since the count gates every read
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_m[r_wptr] <= ar_master;
         r_fifo_s[r_wptr] <= w_slave_norm;
      end
   end

   // FIFO pointers, occupancy and burst state machine
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_sel_m <= 1'b0;
         r_sel_s <= 2'd0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase

         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_sel_m <= r_fifo_m[r_rptr];
                  r_sel_s <= r_fifo_s[r_rptr];
                  r_state <= ST_BURST;
               end
            end
            ST_BURST: begin
               // Only the RLAST handshake ends a burst; length is unbounded
               if (w_last_beat) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_rdata_router.sv
// ---------------------------------------------------------------------------
// tb_axi_rdata_router
// Scoreboard bench for axi_rdata_router. Directed tasks push routing entries,
// load per-slave beat queues and append the expected master-side beats to a
// single ordered scoreboard. A slave model process presents queued beats, and
// a monitor process compares every master-side beat against the scoreboard.
// ---------------------------------------------------------------------------
module tb_axi_rdata_router;

   localparam int unsigned ID_W   = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 4;

   typedef struct {
      logic              m;
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
      logic [1:0]        resp;
      logic              last;
   } beat_t;

   typedef struct {
      int unsigned cyc;
      logic        last;
   } acc_t;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   ar_push;
   logic                   ar_master;
   logic [1:0]             ar_slave;
   logic                   ar_full;
   logic [$clog2(DEPTH):0] outstanding;
   logic [3*ID_W-1:0]      s_rid;
   logic [3*DATA_W-1:0]    s_rdata;
   logic [5:0]             s_rresp;
   logic [2:0]             s_rlast;
   logic [2:0]             s_rvalid;
   logic [2:0]             s_rready;
   logic [2*ID_W-1:0]      m_rid;
   logic [2*DATA_W-1:0]    m_rdata;
   logic [3:0]             m_rresp;
   logic [1:0]             m_rlast;
   logic [1:0]             m_rvalid;
   logic [1:0]             m_rready;

   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned cyc     = 0;

   beat_t exp_q [$];
   beat_t slv_q [3][$];
   acc_t  acc_q [$];
   logic [2:0] hs_pend = '0;

   axi_rdata_router #(.ID_W(ID_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .ar_push    (ar_push),
      .ar_master  (ar_master),
      .ar_slave   (ar_slave),
      .ar_full    (ar_full),
      .outstanding(outstanding),
      .s_rid      (s_rid),
      .s_rdata    (s_rdata),
      .s_rresp    (s_rresp),
      .s_rlast    (s_rlast),
      .s_rvalid   (s_rvalid),
      .s_rready   (s_rready),
      .m_rid      (m_rid),
      .m_rdata    (m_rdata),
      .m_rresp    (m_rresp),
      .m_rlast    (m_rlast),
      .m_rvalid   (m_rvalid),
      .m_rready   (m_rready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Slave model: present queue heads, retire beats that handshook
   initial begin
      s_rvalid = '0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = '0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (hs_pend[k] && slv_q[k].size() != 0) void'(slv_q[k].pop_front());
         end
         for (int k = 0; k < 3; k++) begin
            if (slv_q[k].size() != 0) begin
               s_rvalid[k]                 = 1'b1;
               s_rid[k*ID_W +: ID_W]       = slv_q[k][0].id;
               s_rdata[k*DATA_W +: DATA_W] = slv_q[k][0].data;
               s_rresp[k*2 +: 2]           = slv_q[k][0].resp;
               s_rlast[k]                  = slv_q[k][0].last;
            end else begin
               s_rvalid[k]                 = 1'b0;
               s_rid[k*ID_W +: ID_W]       = '0;
               s_rdata[k*DATA_W +: DATA_W] = '0;
               s_rresp[k*2 +: 2]           = '0;
               s_rlast[k]                  = 1'b0;
            end
         end
         #1;
         hs_pend = s_rvalid & s_rready;
         if (!rst) begin
            for (int k = 0; k < 3; k++) slv_q[k].delete();
            hs_pend = '0;
         end
      end
   end

   // Monitor: compare every presented master beat with the scoreboard head
   initial begin
      beat_t h;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            exp_q.delete();
         end else begin
            if (s_rready != '0) check("s_rready_onehot", 64'($onehot(s_rready)), 1);
            for (int j = 0; j < 2; j++) begin
               if (m_rvalid[j]) begin
                  check("beat_expected", 64'(exp_q.size() != 0), 1);
                  if (exp_q.size() != 0) begin
                     h = exp_q[0];
                     check("beat", {1'(j), m_rid[j*ID_W +: ID_W], m_rdata[j*DATA_W +: DATA_W],
                                    m_rresp[j*2 +: 2], m_rlast[j]},
                                   {h.m, h.id, h.data, h.resp, h.last});
                     if (m_rready[j]) begin
                        void'(exp_q.pop_front());
                        acc_q.push_back('{cyc: cyc, last: h.last});
                     end
                  end
               end
            end
         end
      end
   end

   task automatic nop();
      @(negedge clk);
      ar_push = 1'b0;
   endtask

   task automatic push(input logic m, input logic [1:0] s);
      @(negedge clk);
      ar_push   = 1'b1;
      ar_master = m;
      ar_slave  = s;
   endtask

   task automatic exp_burst(input logic m, input int n, input logic [ID_W-1:0] id,
                            input logic [DATA_W-1:0] base, input logic [1:0] resp);
      for (int i = 0; i < n; i++)
         exp_q.push_back('{m: m, id: id, data: base + DATA_W'(i), resp: resp, last: (i == n-1)});
   endtask

   task automatic slv_burst(input int s, input int n, input logic [ID_W-1:0] id,
                            input logic [DATA_W-1:0] base, input logic [1:0] resp);
      for (int i = 0; i < n; i++)
         slv_q[s].push_back('{m: 1'b0, id: id, data: base + DATA_W'(i), resp: resp, last: (i == n-1)});
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         nop();
         t++;
      end
      check(name, 64'(exp_q.size()), 0);
      repeat (2) nop();
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned p;
      int          t;
      logic [3:0]  pat;
      logic [1:0]  fm [6];
      logic [1:0]  fs [6];

      rst = 1'b0; ar_push = 1'b0; ar_master = 1'b0; ar_slave = 2'd0; m_rready = 2'b11;
      repeat (3) @(negedge clk);
      #3;
      // Reset state
      check("rst_ar_full", 64'(ar_full), 0);
      check("rst_outstanding", 64'(outstanding), 0);
      check("rst_s_rready", 64'(s_rready), 0);
      check("rst_m_rvalid", 64'(m_rvalid), 0);
      check("rst_m_rdata", 64'(m_rdata), 0);
      @(negedge clk);
      rst = 1'b1;
      nop();

      // Single burst: master 1 from slave 0, latency and outstanding profile
      acc_q.delete();
      push(1'b1, 2'd0);
      p = cyc;
      exp_burst(1'b1, 4, 4'h5, 32'hA0, 2'b01);
      slv_burst(0, 4, 4'h5, 32'hA0, 2'b01);
      #3 check("t1_out_push", 64'(outstanding), 0);
      nop();
      #3 check("t1_out_pop", 64'(outstanding), 1);
      check("t1_no_valid_yet", 64'(m_rvalid), 0);
      nop();
      #3 check("t1_out_burst", 64'(outstanding), 1);
      check("t1_m_rvalid", 64'(m_rvalid), 2'b10);
      check("t1_s_rready", 64'(s_rready), 3'b001);
      check("t1_m0_data_zero", 64'(m_rdata[DATA_W-1:0]), 0);
      drain("t1_drain");
      #3 check("t1_out_done", 64'(outstanding), 0);
      check("t1_first_beat_cyc", 64'(acc_q[0].cyc), 64'(p + 2));
      check("t1_beats", 64'(acc_q.size()), 4);

      // Ordering and bubble: both slaves valid from the start
      acc_q.delete();
      push(1'b0, 2'd1);
      exp_burst(1'b0, 3, 4'h1, 32'hB0, 2'b00);
      slv_burst(1, 3, 4'h1, 32'hB0, 2'b00);
      push(1'b1, 2'd2);
      exp_burst(1'b1, 2, 4'h2, 32'hC0, 2'b11);
      slv_burst(2, 2, 4'h2, 32'hC0, 2'b11);
      nop();
      drain("t2_drain");
      check("t2_beats", 64'(acc_q.size()), 5);
      if (acc_q.size() == 5) begin
         check("t2_contig", 64'(acc_q[1].cyc), 64'(acc_q[0].cyc + 1));
         check("t2_bubble", 64'(acc_q[3].cyc), 64'(acc_q[2].cyc + 2));
      end

      // Backpressure: master ready pattern 1,0,0,1 mid-burst
      push(1'b1, 2'd1);
      exp_burst(1'b1, 4, 4'h7, 32'hD0, 2'b01);
      slv_burst(1, 4, 4'h7, 32'hD0, 2'b01);
      nop();
      nop();
      pat = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         m_rready = {pat[i], 1'b1};
         #3;
         check("t3_s_rready", 64'(s_rready), 64'({1'b0, pat[i], 1'b0}));
         check("t3_m_rvalid", 64'(m_rvalid), 2'b10);
      end
      @(negedge clk);
      m_rready = 2'b11;
      drain("t3_drain");

      // Full and wrap
      fm = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
      fs = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
      for (int i = 0; i < 4; i++) begin
         push(fm[i][0], fs[i]);
         exp_burst(fm[i][0], 2, 4'(i), 32'h100 + DATA_W'(16*i), 2'b00);
      end
      push(fm[4][0], fs[4]);
      exp_burst(fm[4][0], 2, 4'(4), 32'h140, 2'b00);
      #3 check("t4_out4", 64'(outstanding), 4);
      check("t4_not_full", 64'(ar_full), 0);
      push(fm[5][0], fs[5]);
      #3 check("t4_full", 64'(ar_full), 1);
      check("t4_out5", 64'(outstanding), 5);
      nop();
      #3 check("t4_full_held", 64'(ar_full), 1);
      check("t4_out_dropped", 64'(outstanding), 5);
      for (int i = 0; i < 5; i++) slv_burst(int'(fs[i]), 2, 4'(i), 32'h100 + DATA_W'(16*i), 2'b00);
      drain("t4_drain");
      #3 check("t4_out_empty", 64'(outstanding), 0);
      fm = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
      fs = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
      for (int i = 0; i < 4; i++) begin
         push(fm[i][0], fs[i]);
         exp_burst(fm[i][0], 3, 4'(8 + i), 32'h200 + DATA_W'(16*i), (fs[i] >= 2) ? 2'b11 : 2'b00);
         slv_burst((fs[i] == 2'd3) ? 2 : int'(fs[i]), 3, 4'(8 + i), 32'h200 + DATA_W'(16*i),
                   (fs[i] >= 2) ? 2'b11 : 2'b00);
      end
      nop();
      drain("t4_wrap_drain");
      #3 check("t4_wrap_out", 64'(outstanding), 0);

      // Simultaneous push and pop, slave index 3 aliases to 2
      push(1'b0, 2'd0);
      exp_burst(1'b0, 2, 4'h3, 32'hE0, 2'b00);
      slv_burst(0, 2, 4'h3, 32'hE0, 2'b00);
      push(1'b1, 2'd3);
      exp_burst(1'b1, 3, 4'h4, 32'hF0, 2'b11);
      slv_burst(2, 3, 4'h4, 32'hF0, 2'b11);
      #3 check("t5_out_pop_cycle", 64'(outstanding), 1);
      nop();
      #3 check("t5_out_after", 64'(outstanding), 2);
      drain("t5_drain");

      // Reset mid-burst
      acc_q.delete();
      push(1'b0, 2'd1);
      exp_burst(1'b0, 4, 4'h9, 32'h300, 2'b00);
      slv_burst(1, 4, 4'h9, 32'h300, 2'b00);
      t = 0;
      do begin
         nop();
         #3;
         t++;
      end while (acc_q.size() < 2 && t < 50);
      check("t6_two_beats", 64'(acc_q.size()), 2);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #3;
      check("t6_m_rvalid", 64'(m_rvalid), 0);
      check("t6_s_rready", 64'(s_rready), 0);
      check("t6_outstanding", 64'(outstanding), 0);
      check("t6_ar_full", 64'(ar_full), 0);
      check("t6_m_rdata", 64'(m_rdata), 0);
      push(1'b1, 2'd2);
      exp_burst(1'b1, 2, 4'hA, 32'h400, 2'b11);
      slv_burst(2, 2, 4'hA, 32'h400, 2'b11);
      nop();
      drain("t6_after_drain");
      #3 check("t6_out_final", 64'(outstanding), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
